// File: rtl/pc_unit_if.sv
// Branch-control inputs and fetch-address outputs of the PC stage.
// master drives the controls (branch FSM / decode), slave is pc_unit.
interface pc_unit_if #(
  parameter int WIDTH    = 16,
  parameter int OFFSET_W = 9
);
  logic                latch_en_in;
  logic                pc_ctl_0_in;
  logic                pc_ctl_1_in;
  logic [OFFSET_W-1:0] offset_in;
  logic [WIDTH-1:0]    reg_target_in;
  logic                halt_in;
  logic                push_in;
  logic                pop_in;
  logic [WIDTH-1:0]    pc_out;
  logic [WIDTH-1:0]    npc_out;
  logic                halted_out;
  logic [WIDTH-1:0]    instr_count_out;
  logic                ras_err_out;

  modport master (
    output latch_en_in, pc_ctl_0_in, pc_ctl_1_in, offset_in, reg_target_in,
           halt_in, push_in, pop_in,
    input  pc_out, npc_out, halted_out, instr_count_out, ras_err_out
  );

  modport slave (
    input  latch_en_in, pc_ctl_0_in, pc_ctl_1_in, offset_in, reg_target_in,
           halt_in, push_in, pop_in,
    output pc_out, npc_out, halted_out, instr_count_out, ras_err_out
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter stage: next-PC select, saturating retire counter, all state on negedge clka.
// Optional circular return-address stack enabled by defining PC_RAS_EN.
module pc_unit #(
  parameter int               WIDTH        = 16,
  parameter int               OFFSET_W     = 9,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h3000,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic       clka,
  input  logic       reset_in,
  pc_unit_if.slave   bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] ONE = 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_count;

  logic [WIDTH-1:0] w_npc;
  logic [WIDTH-1:0] w_offset_sext;
  logic [WIDTH-1:0] w_branch;

  assign w_npc         = r_pc + ONE;
  assign w_offset_sext = {{(WIDTH-OFFSET_W){bus.offset_in[OFFSET_W-1]}}, bus.offset_in};
  assign w_branch      = w_npc + w_offset_sext;

  assign bus.pc_out          = r_pc;
  assign bus.npc_out         = w_npc;
  assign bus.halted_out      = (r_state == HALT);
  assign bus.instr_count_out = r_count;

`ifdef PC_RAS_EN
  localparam int SP_W = $clog2(RAS_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE   = 1;
  localparam logic [SP_W:0]   CNT_ONE  = 1;
  localparam logic [SP_W:0]   CNT_FULL = RAS_DEPTH[SP_W:0];

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [SP_W:0]    r_ras_cnt;
  logic             r_ras_err;
  logic [SP_W-1:0]  w_sp_dec;
  logic             w_push_wr;

  assign w_sp_dec        = r_sp - SP_ONE;
  assign bus.ras_err_out = r_ras_err;
  assign w_push_wr = !reset_in && (r_state == RUN) && bus.latch_en_in && !bus.halt_in &&
                     !bus.pc_ctl_1_in && !bus.pop_in && bus.push_in;

  // Storage needs no reset; r_ras_cnt alone defines which entries are live.
  always_ff @(negedge clka) begin
    if (w_push_wr) begin
      r_ras[r_sp] <= w_npc;
    end
  end
`else
  logic w_unused_ras;
  assign w_unused_ras    = bus.push_in ^ bus.pop_in;
  assign bus.ras_err_out = 1'b0;
`endif

  always_ff @(negedge clka) begin
    if (reset_in) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_count <= '0;
`ifdef PC_RAS_EN
      r_sp      <= '0;
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (bus.latch_en_in) begin
            if (r_count != '1) begin
              r_count <= r_count + ONE;
            end
            if (bus.halt_in) begin
              r_state <= HALT;
            end else if (bus.pc_ctl_1_in) begin
              r_pc <= bus.reg_target_in;
`ifdef PC_RAS_EN
            end else if (bus.pop_in) begin
              if (r_ras_cnt == '0) begin
                r_pc      <= w_npc;
                r_ras_err <= 1'b1;
              end else begin
                r_pc      <= r_ras[w_sp_dec];
                r_sp      <= w_sp_dec;
                r_ras_cnt <= r_ras_cnt - CNT_ONE;
              end
            end else if (bus.push_in) begin
              // Full stack: the write pointer wraps onto the oldest entry.
              r_pc <= w_branch;
              r_sp <= r_sp + SP_ONE;
              if (r_ras_cnt == CNT_FULL) begin
                r_ras_err <= 1'b1;
              end else begin
                r_ras_cnt <= r_ras_cnt + CNT_ONE;
              end
`endif
            end else if (bus.pc_ctl_0_in) begin
              r_pc <= w_branch;
            end else begin
              r_pc <= w_npc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized edges against a queue/integer reference model.
module tb_pc_unit;

  logic clka = 1'b1;
  logic reset_in;
  always #5 clka = ~clka;

  pc_unit_if #(.WIDTH(16), .OFFSET_W(9)) bus ();

  pc_unit dut (
    .clka     (clka),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  bit          m_boot;
  bit          m_halt;
  bit          m_err;
  logic [15:0] m_stack[$];

  task automatic clear_ctl();
    bus.latch_en_in   = 1'b0;
    bus.pc_ctl_0_in   = 1'b0;
    bus.pc_ctl_1_in   = 1'b0;
    bus.offset_in     = '0;
    bus.reg_target_in = '0;
    bus.halt_in       = 1'b0;
    bus.push_in       = 1'b0;
    bus.pop_in        = 1'b0;
  endtask

  // One falling edge; the model consumes the same inputs the DUT sees.
  task automatic tick();
    logic        rs  = reset_in;
    logic        le  = bus.latch_en_in;
    logic        c0  = bus.pc_ctl_0_in;
    logic        c1  = bus.pc_ctl_1_in;
    logic [8:0]  off = bus.offset_in;
    logic [15:0] tgt = bus.reg_target_in;
    logic        hl  = bus.halt_in;
    logic        pu  = bus.push_in;
    logic        po  = bus.pop_in;
    int          so;
    so = int'(off);
    if (off[8]) so = so - 512;
    @(negedge clka);
    if (rs) begin
      m_pc = 16'h3000; m_cnt = 0; m_boot = 1; m_halt = 0; m_err = 0;
      m_stack.delete();
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt && le) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (hl) m_halt = 1;
      else if (c1) m_pc = tgt;
`ifdef PC_RAS_EN
      else if (po) begin
        if (m_stack.size() == 0) begin m_pc = 16'(int'(m_pc) + 1); m_err = 1; end
        else m_pc = m_stack.pop_back();
      end else if (pu) begin
        if (m_stack.size() == 4) begin void'(m_stack.pop_front()); m_err = 1; end
        m_stack.push_back(16'(int'(m_pc) + 1));
        m_pc = 16'(int'(m_pc) + 1 + so);
      end
`endif
      else if (c0) m_pc = 16'(int'(m_pc) + 1 + so);
      else m_pc = 16'(int'(m_pc) + 1);
    end
    if (pu || po) so = so; // push/pop only matter when the stack exists
    #1;
  endtask

  task automatic do_reset();
    clear_ctl();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    bus.latch_en_in = 1'b1; bus.pc_ctl_1_in = 1'b1; bus.reg_target_in = 16'h1234;
    reset_in = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.pc_out !== 16'h3000) $display("FAIL reset_pc: got %h want 3000", bus.pc_out); else n_pass++;
    n_chk++; if (bus.npc_out !== 16'h3001) $display("FAIL reset_npc: got %h want 3001", bus.npc_out); else n_pass++;
    n_chk++; if (bus.instr_count_out !== 16'h0000) $display("FAIL reset_cnt: got %h want 0000", bus.instr_count_out); else n_pass++;
    n_chk++; if (bus.halted_out !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus.halted_out); else n_pass++;
    n_chk++; if (bus.ras_err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.ras_err_out); else n_pass++;
    reset_in = 1'b0;
    clear_ctl();
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc [4] = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
    do_reset();
    bus.latch_en_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++; if (bus.pc_out !== exp_pc[i]) $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc_out, exp_pc[i]); else n_pass++;
    end
    n_chk++; if (bus.instr_count_out !== 16'd3) $display("FAIL seq_cnt: got %0d want 3", bus.instr_count_out); else n_pass++;
    clear_ctl();
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.pc_ctl_1_in = 1'b1; bus.reg_target_in = 16'h3010;
    tick();
    bus.pc_ctl_1_in = 1'b0; bus.pc_ctl_0_in = 1'b1; bus.offset_in = 9'h1FE;
    tick();
    n_chk++; if (bus.pc_out !== 16'h300F) $display("FAIL branch_neg: got %h want 300F", bus.pc_out); else n_pass++;
    bus.pc_ctl_0_in = 1'b0; bus.pc_ctl_1_in = 1'b1;
    tick();
    bus.pc_ctl_1_in = 1'b0; bus.pc_ctl_0_in = 1'b1; bus.offset_in = 9'h0FF;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3110) $display("FAIL branch_pos: got %h want 3110", bus.pc_out); else n_pass++;
    clear_ctl();
  endtask

  task automatic test_jump_priority();
    logic [15:0] cnt0;
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.pc_ctl_0_in = 1'b1; bus.pc_ctl_1_in = 1'b1;
    bus.offset_in = 9'h005; bus.reg_target_in = 16'h4000;
    tick();
    n_chk++; if (bus.pc_out !== 16'h4000) $display("FAIL jump_prio: got %h want 4000", bus.pc_out); else n_pass++;
    cnt0 = bus.instr_count_out;
    bus.latch_en_in = 1'b0; bus.reg_target_in = 16'h5555; bus.halt_in = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.pc_out !== 16'h4000) $display("FAIL latch_off_pc: got %h want 4000", bus.pc_out); else n_pass++;
    n_chk++; if (bus.instr_count_out !== cnt0 || bus.halted_out !== 1'b0)
      $display("FAIL latch_off_state: got cnt %h halted %b want cnt %h halted 0", bus.instr_count_out, bus.halted_out, cnt0);
    else n_pass++;
    clear_ctl();
  endtask

  task automatic test_wrap_halt();
    logic [15:0] cnt0;
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.pc_ctl_1_in = 1'b1; bus.reg_target_in = 16'hFFFF;
    tick();
    bus.pc_ctl_1_in = 1'b0; bus.pc_ctl_0_in = 1'b1; bus.offset_in = 9'h1FF;
    tick();
    n_chk++; if (bus.pc_out !== 16'hFFFF) $display("FAIL wrap_branch: got %h want FFFF", bus.pc_out); else n_pass++;
    n_chk++; if (bus.npc_out !== 16'h0000) $display("FAIL wrap_npc: got %h want 0000", bus.npc_out); else n_pass++;
    bus.pc_ctl_0_in = 1'b0;
    tick();
    n_chk++; if (bus.pc_out !== 16'h0000) $display("FAIL wrap_seq: got %h want 0000", bus.pc_out); else n_pass++;
    cnt0 = bus.instr_count_out;
    bus.halt_in = 1'b1;
    tick();
    n_chk++; if (bus.halted_out !== 1'b1 || bus.pc_out !== 16'h0000)
      $display("FAIL halt_enter: got halted %b pc %h want 1 0000", bus.halted_out, bus.pc_out);
    else n_pass++;
    n_chk++; if (bus.instr_count_out !== cnt0 + 16'd1) $display("FAIL halt_cnt: got %h want %h", bus.instr_count_out, cnt0 + 16'd1); else n_pass++;
    bus.halt_in = 1'b0; bus.pc_ctl_1_in = 1'b1; bus.reg_target_in = 16'h7777;
    for (int i = 0; i < 10; i++) tick();
    n_chk++; if (bus.pc_out !== 16'h0000 || bus.instr_count_out !== cnt0 + 16'd1 || bus.halted_out !== 1'b1)
      $display("FAIL halt_hold: got pc %h cnt %h halted %b want 0000 %h 1", bus.pc_out, bus.instr_count_out, bus.halted_out, cnt0 + 16'd1);
    else n_pass++;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    n_chk++; if (bus.pc_out !== 16'h3000 || bus.halted_out !== 1'b0)
      $display("FAIL halt_reset: got pc %h halted %b want 3000 0", bus.pc_out, bus.halted_out);
    else n_pass++;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3000) $display("FAIL halt_reset_boot: got %h want 3000", bus.pc_out); else n_pass++;
    clear_ctl();
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    logic [15:0] exp_pop [5] = '{16'h300D, 16'h300A, 16'h3007, 16'h3004, 16'h3005};
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.push_in = 1'b1; bus.offset_in = 9'h002;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) begin
        n_chk++; if (bus.ras_err_out !== 1'b0) $display("FAIL ras_err_early: got %b want 0", bus.ras_err_out); else n_pass++;
      end
    end
    n_chk++; if (bus.ras_err_out !== 1'b1) $display("FAIL ras_err_overflow: got %b want 1", bus.ras_err_out); else n_pass++;
    bus.push_in = 1'b0; bus.pop_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (bus.pc_out !== exp_pop[i]) $display("FAIL ras_pop[%0d]: got %h want %h", i, bus.pc_out, exp_pop[i]); else n_pass++;
    end
    n_chk++; if (bus.ras_err_out !== 1'b1) $display("FAIL ras_err_sticky: got %b want 1", bus.ras_err_out); else n_pass++;
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.push_in = 1'b1; bus.offset_in = 9'h002;
    tick();
    bus.pop_in = 1'b1;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3001 || bus.ras_err_out !== 1'b0)
      $display("FAIL ras_pop_wins: got pc %h err %b want 3001 0", bus.pc_out, bus.ras_err_out);
    else n_pass++;
    bus.push_in = 1'b0;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3002 || bus.ras_err_out !== 1'b1)
      $display("FAIL ras_underflow: got pc %h err %b want 3002 1", bus.pc_out, bus.ras_err_out);
    else n_pass++;
    clear_ctl();
  endtask
`else
  task automatic test_ras();
    do_reset();
    tick();
    bus.latch_en_in = 1'b1; bus.push_in = 1'b1; bus.offset_in = 9'h004;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3001) $display("FAIL ras_off_push: got %h want 3001", bus.pc_out); else n_pass++;
    bus.pc_ctl_0_in = 1'b1;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3006) $display("FAIL ras_off_push_br: got %h want 3006", bus.pc_out); else n_pass++;
    bus.push_in = 1'b0; bus.pc_ctl_0_in = 1'b0; bus.pop_in = 1'b1;
    tick();
    n_chk++; if (bus.pc_out !== 16'h3007 || bus.ras_err_out !== 1'b0)
      $display("FAIL ras_off_pop: got pc %h err %b want 3007 0", bus.pc_out, bus.ras_err_out);
    else n_pass++;
    clear_ctl();
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset_in          = ($urandom_range(63) == 0);
      bus.latch_en_in   = $urandom_range(1);
      bus.pc_ctl_0_in   = $urandom_range(1);
      bus.pc_ctl_1_in   = ($urandom_range(3) == 0);
      bus.offset_in     = 9'($urandom);
      bus.reg_target_in = 16'($urandom);
      bus.halt_in       = ($urandom_range(40) == 0);
      bus.push_in       = ($urandom_range(3) == 0);
      bus.pop_in        = ($urandom_range(3) == 0);
      tick();
      n_chk++;
      if (bus.pc_out !== m_pc || bus.npc_out !== 16'(m_pc + 16'd1) || bus.instr_count_out !== m_cnt ||
          bus.halted_out !== m_halt || bus.ras_err_out !== m_err) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got pc %h npc %h cnt %h h %b e %b want pc %h npc %h cnt %h h %b e %b",
                   i, bus.pc_out, bus.npc_out, bus.instr_count_out, bus.halted_out, bus.ras_err_out,
                   m_pc, 16'(m_pc + 16'd1), m_cnt, m_halt, m_err);
        errs++;
      end else n_pass++;
    end
    reset_in = 1'b0;
    clear_ctl();
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    bus.latch_en_in = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    n_chk++; if (bus.instr_count_out !== 16'hFFFF) $display("FAIL sat_reach: got %h want FFFF", bus.instr_count_out); else n_pass++;
    tick();
    tick();
    n_chk++; if (bus.instr_count_out !== 16'hFFFF) $display("FAIL sat_hold: got %h want FFFF", bus.instr_count_out); else n_pass++;
    n_chk++; if (bus.pc_out !== m_pc) $display("FAIL sat_pc: got %h want %h", bus.pc_out, m_pc); else n_pass++;
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    reset_in = 1'b1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_wrap_halt();
    test_ras();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
